// File: rtl/video_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_generator
// Purpose  : Raster timing generator with shifted active window and pixEn.
// Revision : 1.0
// ============================================================================
module video_timing_generator #(
    parameter int H_ACTIVE   = 256,
    parameter int H_BACK     = 9,
    parameter int H_FRONT    = 22,
    parameter int H_SYNC     = 23,
    parameter int V_ACTIVE   = 192,
    parameter int V_BACK     = 26,
    parameter int V_FRONT    = 42,
    parameter int V_SYNC     = 3,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int SHIFT_W    = 4,
    parameter int POS_W      = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pixEn,
    input  logic [SHIFT_W-1:0]        hShift,
    input  logic [SHIFT_W-1:0]        vShift,
    output logic                      hSync,
    output logic                      vSync,
    output logic                      hBlank,
    output logic                      vBlank,
    output logic                      isActive,
    output logic                      lineStart,
    output logic                      frameStart,
    output logic signed [POS_W-1:0]   xPos,
    output logic signed [POS_W-1:0]   yPos
);

    localparam int H_TOTAL = H_BACK + H_ACTIVE + H_FRONT + H_SYNC;
    localparam int V_TOTAL = V_BACK + V_ACTIVE + V_FRONT + V_SYNC;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST       = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST       = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] H_SYNC_START = HC_W'(H_TOTAL - H_SYNC);
    localparam logic [VC_W-1:0] V_SYNC_START = VC_W'(V_TOTAL - V_SYNC);

    localparam logic signed [POS_W-1:0] H_BACK_P   = POS_W'(H_BACK);
    localparam logic signed [POS_W-1:0] V_BACK_P   = POS_W'(V_BACK);
    localparam logic signed [POS_W-1:0] H_ACTIVE_P = POS_W'(H_ACTIVE);
    localparam logic signed [POS_W-1:0] V_ACTIVE_P = POS_W'(V_ACTIVE);
    localparam logic signed [POS_W-1:0] X_RESET    = POS_W'(0 - H_BACK);
    localparam logic signed [POS_W-1:0] Y_RESET    = POS_W'(0 - V_BACK);

    // A shifted window must never spill into the sync region.
    if (H_FRONT < (2 ** SHIFT_W) - 1) begin : g_chk_h_front
        $fatal(1, "H_FRONT too small for SHIFT_W");
    end
    if (V_FRONT < (2 ** SHIFT_W) - 1) begin : g_chk_v_front
        $fatal(1, "V_FRONT too small for SHIFT_W");
    end
    if ((2 ** (POS_W - 1)) <= H_TOTAL || (2 ** (POS_W - 1)) <= V_TOTAL) begin : g_chk_pos_w
        $fatal(1, "POS_W too narrow for raster totals");
    end
    if (H_ACTIVE < 1 || H_BACK < 1 || H_FRONT < 1 || H_SYNC < 1 ||
        V_ACTIVE < 1 || V_BACK < 1 || V_FRONT < 1 || V_SYNC < 1) begin : g_chk_geom
        $fatal(1, "all geometry parameters must be >= 1");
    end

    logic [HC_W-1:0]         col_cnt;
    logic [VC_W-1:0]         line_cnt;
    logic [SHIFT_W-1:0]      h_shift_l;
    logic [SHIFT_W-1:0]      v_shift_l;
    logic signed [POS_W-1:0] x_next;
    logic signed [POS_W-1:0] y_next;
    logic                    h_blank_next;
    logic                    v_blank_next;
    logic                    col_wrap;
    logic                    line_wrap;

    always_comb begin
        col_wrap     = (col_cnt == H_LAST);
        line_wrap    = (line_cnt == V_LAST);
        x_next       = $signed({{(POS_W-HC_W){1'b0}}, col_cnt}) - H_BACK_P
                     - $signed({{(POS_W-SHIFT_W){1'b0}}, h_shift_l});
        y_next       = $signed({{(POS_W-VC_W){1'b0}}, line_cnt}) - V_BACK_P
                     - $signed({{(POS_W-SHIFT_W){1'b0}}, v_shift_l});
        h_blank_next = x_next[POS_W-1] || (x_next >= H_ACTIVE_P);
        v_blank_next = y_next[POS_W-1] || (y_next >= V_ACTIVE_P);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt    <= '0;
            line_cnt   <= '0;
            h_shift_l  <= hShift;
            v_shift_l  <= vShift;
            hSync      <= !H_SYNC_POL;
            vSync      <= !V_SYNC_POL;
            hBlank     <= 1'b1;
            vBlank     <= 1'b1;
            isActive   <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            xPos       <= X_RESET;
            yPos       <= Y_RESET;
        end else if (pixEn) begin
            // Outputs describe the position held in the counters before this edge.
            hSync      <= (col_cnt >= H_SYNC_START) ? H_SYNC_POL : !H_SYNC_POL;
            vSync      <= (line_cnt >= V_SYNC_START) ? V_SYNC_POL : !V_SYNC_POL;
            hBlank     <= h_blank_next;
            vBlank     <= v_blank_next;
            isActive   <= !h_blank_next && !v_blank_next;
            lineStart  <= (col_cnt == '0);
            frameStart <= (col_cnt == '0) && (line_cnt == '0);
            xPos       <= x_next;
            yPos       <= y_next;

            if (col_wrap) begin
                col_cnt <= '0;
                if (line_wrap) begin
                    line_cnt  <= '0;
                    h_shift_l <= hShift;
                    v_shift_l <= vShift;
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_generator
// Purpose  : Scoreboard bench for three raster geometries of the generator.
// Revision : 1.0
// ============================================================================
module tb_video_timing_generator;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        act;
        logic        ls;
        logic        fs;
        logic [15:0] x;
        logic [15:0] y;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default raster
    logic a_rst, a_en, a_hs, a_vs, a_hb, a_vb, a_act, a_ls, a_fs;
    logic [3:0] a_hsh, a_vsh;
    logic signed [9:0] a_x, a_y;
    // DUT B: tiny raster, negative sync polarity
    logic b_rst, b_en, b_hs, b_vs, b_hb, b_vb, b_act, b_ls, b_fs;
    logic [1:0] b_hsh, b_vsh;
    logic signed [5:0] b_x, b_y;
    // DUT C: 400-wide line, negative sync polarity
    logic c_rst, c_en, c_hs, c_vs, c_hb, c_vb, c_act, c_ls, c_fs;
    logic [3:0] c_hsh, c_vsh;
    logic signed [9:0] c_x, c_y;

    video_timing_generator u_a (
        .clk(clk), .reset(a_rst), .pixEn(a_en), .hShift(a_hsh), .vShift(a_vsh),
        .hSync(a_hs), .vSync(a_vs), .hBlank(a_hb), .vBlank(a_vb), .isActive(a_act),
        .lineStart(a_ls), .frameStart(a_fs), .xPos(a_x), .yPos(a_y));

    video_timing_generator #(
        .H_ACTIVE(8), .H_BACK(2), .H_FRONT(3), .H_SYNC(2),
        .V_ACTIVE(4), .V_BACK(1), .V_FRONT(3), .V_SYNC(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .SHIFT_W(2), .POS_W(6)
    ) u_b (
        .clk(clk), .reset(b_rst), .pixEn(b_en), .hShift(b_hsh), .vShift(b_vsh),
        .hSync(b_hs), .vSync(b_vs), .hBlank(b_hb), .vBlank(b_vb), .isActive(b_act),
        .lineStart(b_ls), .frameStart(b_fs), .xPos(b_x), .yPos(b_y));

    video_timing_generator #(
        .H_ACTIVE(320), .H_BACK(16), .H_FRONT(16), .H_SYNC(48),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) u_c (
        .clk(clk), .reset(c_rst), .pixEn(c_en), .hShift(c_hsh), .vShift(c_vsh),
        .hSync(c_hs), .vSync(c_vs), .hBlank(c_hb), .vBlank(c_vb), .isActive(c_act),
        .lineStart(c_ls), .frameStart(c_fs), .xPos(c_x), .yPos(c_y));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    obs_t sb[$];

    int g_hb[3], g_ha[3], g_hf[3], g_hsn[3], g_vb[3], g_va[3], g_vf[3], g_vsn[3];
    bit g_hp[3], g_vp[3];
    int m_col[3], m_line[3], m_hsl[3], m_vsl[3];
    obs_t m_last[3];

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_i(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic obs_t reset_obs(input int d);
        obs_t o;
        o     = '0;
        o.hs  = !g_hp[d];
        o.vs  = !g_vp[d];
        o.hb  = 1'b1;
        o.vb  = 1'b1;
        o.x   = 16'(0 - g_hb[d]);
        o.y   = 16'(0 - g_vb[d]);
        return o;
    endfunction

    // Output expected from the raster position the counters hold before the edge.
    function automatic obs_t model_out(input int d);
        obs_t o;
        int htot, vtot, x, y;
        bit hin, vin;
        htot  = g_hb[d] + g_ha[d] + g_hf[d] + g_hsn[d];
        vtot  = g_vb[d] + g_va[d] + g_vf[d] + g_vsn[d];
        x     = m_col[d] - g_hb[d] - m_hsl[d];
        y     = m_line[d] - g_vb[d] - m_vsl[d];
        hin   = (x >= 0) && (x < g_ha[d]);
        vin   = (y >= 0) && (y < g_va[d]);
        o     = '0;
        o.hs  = (m_col[d] >= htot - g_hsn[d]) ? g_hp[d] : !g_hp[d];
        o.vs  = (m_line[d] >= vtot - g_vsn[d]) ? g_vp[d] : !g_vp[d];
        o.hb  = !hin;
        o.vb  = !vin;
        o.act = hin && vin;
        o.ls  = (m_col[d] == 0);
        o.fs  = (m_col[d] == 0) && (m_line[d] == 0);
        o.x   = 16'(x);
        o.y   = 16'(y);
        return o;
    endfunction

    task automatic advance(input int d, input int hsh, input int vsh);
        int htot, vtot;
        htot = g_hb[d] + g_ha[d] + g_hf[d] + g_hsn[d];
        vtot = g_vb[d] + g_va[d] + g_vf[d] + g_vsn[d];
        if (m_col[d] == htot - 1) begin
            m_col[d] = 0;
            if (m_line[d] == vtot - 1) begin
                m_line[d] = 0;
                m_hsl[d]  = hsh;
                m_vsl[d]  = vsh;
            end else begin
                m_line[d] = m_line[d] + 1;
            end
        end else begin
            m_col[d] = m_col[d] + 1;
        end
    endtask

    function automatic obs_t observe(input int d);
        obs_t o;
        int xi, yi;
        o = '0;
        case (d)
            0: begin
                o.hs = a_hs; o.vs = a_vs; o.hb = a_hb; o.vb = a_vb;
                o.act = a_act; o.ls = a_ls; o.fs = a_fs; xi = a_x; yi = a_y;
            end
            1: begin
                o.hs = b_hs; o.vs = b_vs; o.hb = b_hb; o.vb = b_vb;
                o.act = b_act; o.ls = b_ls; o.fs = b_fs; xi = b_x; yi = b_y;
            end
            default: begin
                o.hs = c_hs; o.vs = c_vs; o.hb = c_hb; o.vb = c_vb;
                o.act = c_act; o.ls = c_ls; o.fs = c_fs; xi = c_x; yi = c_y;
            end
        endcase
        o.x = 16'(xi);
        o.y = 16'(yi);
        return o;
    endfunction

    // One clock: drive, push expectation, clock, pop and compare.
    task automatic step(input int d, input bit en, input bit rst, input int hsh,
                        input int vsh, output obs_t got);
        obs_t e;
        a_en = 1'b0;
        b_en = 1'b0;
        c_en = 1'b0;
        case (d)
            0: begin a_en = en; a_rst = rst; a_hsh = 4'(hsh); a_vsh = 4'(vsh); end
            1: begin b_en = en; b_rst = rst; b_hsh = 2'(hsh); b_vsh = 2'(vsh); end
            default: begin c_en = en; c_rst = rst; c_hsh = 4'(hsh); c_vsh = 4'(vsh); end
        endcase
        if (rst) begin
            e         = reset_obs(d);
            m_col[d]  = 0;
            m_line[d] = 0;
            m_hsl[d]  = hsh;
            m_vsl[d]  = vsh;
        end else if (en) begin
            e = model_out(d);
            advance(d, hsh, vsh);
        end else begin
            e = m_last[d];
        end
        m_last[d] = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = observe(d);
        e   = sb.pop_front();
        check_obs($sformatf("sb%0d@%0d", d, cyc), got, e);
    endtask

    initial begin
        obs_t g;
        int act_cnt, first_act, last_act, first_x, first_y, last_x, last_y;
        int ls_cnt, vs_cnt, hs_cnt, fs2, prev_hs, prev_fs, r0, r1, lo_cnt, first_lo;

        g_hb  = '{9, 2, 16};   g_ha  = '{256, 8, 320};
        g_hf  = '{22, 3, 16};  g_hsn = '{23, 2, 48};
        g_vb  = '{26, 1, 26};  g_va  = '{192, 4, 192};
        g_vf  = '{42, 3, 42};  g_vsn = '{3, 2, 3};
        g_hp  = '{1'b1, 1'b0, 1'b0};
        g_vp  = '{1'b1, 1'b0, 1'b0};

        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
        a_hsh = '0; a_vsh = '0; b_hsh = '0; b_vsh = '0; c_hsh = '0; c_vsh = '0;

        // ---- Default raster: one full frame with pixEn always high ----
        step(0, 1'b0, 1'b1, 0, 0, g);
        check_i("A reset xPos", $signed(g.x), -9);
        check_i("A reset yPos", $signed(g.y), -26);
        step(0, 1'b1, 1'b1, 0, 0, g);
        act_cnt = 0; first_act = -1; last_act = -1; ls_cnt = 0; vs_cnt = 0;
        hs_cnt = 0; fs2 = -1; prev_hs = 0; r0 = -1; r1 = -1;
        first_x = 0; first_y = 0; last_x = 0; last_y = 0;
        for (int i = 0; i <= 81530; i++) begin
            step(0, 1'b1, 1'b0, 0, 0, g);
            if (i == 0) begin
                check_i("A first frameStart", int'(g.fs), 1);
                check_i("A first lineStart", int'(g.ls), 1);
            end
            if (i < 81530) begin
                if (g.act) begin
                    act_cnt++;
                    if (first_act < 0) begin
                        first_act = i; first_x = $signed(g.x); first_y = $signed(g.y);
                    end
                    last_act = i; last_x = $signed(g.x); last_y = $signed(g.y);
                end
                if (g.ls) ls_cnt++;
                if (g.vs) vs_cnt++;
                if (g.hs && i < 310) hs_cnt++;
                if (g.hs && prev_hs == 0) begin
                    if (r0 < 0) r0 = i;
                    else if (r1 < 0) r1 = i;
                end
                prev_hs = g.hs;
            end else if (g.fs) begin
                fs2 = i;
            end
        end
        check_i("A active count", act_cnt, 49152);
        check_i("A first active idx", first_act, 26 * 310 + 9);
        check_i("A first active x", first_x, 0);
        check_i("A first active y", first_y, 0);
        check_i("A last active idx", last_act, 217 * 310 + 264);
        check_i("A last active x", last_x, 255);
        check_i("A last active y", last_y, 191);
        check_i("A lineStart count", ls_cnt, 263);
        check_i("A vSync cycles", vs_cnt, 930);
        check_i("A hSync width", hs_cnt, 23);
        check_i("A hSync first", r0, 287);
        check_i("A hSync period", r1 - r0, 310);
        check_i("A frameStart period", fs2, 81530);

        // ---- Tiny raster: mid-frame shift change takes effect next frame ----
        step(1, 1'b0, 1'b1, 0, 0, g);
        step(1, 1'b0, 1'b1, 0, 0, g);
        first_act = -1; r0 = -1;
        for (int i = 0; i < 320; i++) begin
            step(1, 1'b1, 1'b0, (i >= 40) ? 3 : 0, (i >= 40) ? 2 : 0, g);
            if (i == 150) check_i("B frameStart 2", int'(g.fs), 1);
            if (g.act && i < 150 && first_act < 0) first_act = i;
            if (g.act && i >= 150 && r0 < 0) begin
                r0 = i;
                check_i("B shifted first x", $signed(g.x), 0);
            end
        end
        check_i("B first active frame1", first_act, 17);
        check_i("B first active frame2", r0, 150 + 45 + 5);

        // ---- pixEn every other cycle doubles the frame period ----
        prev_fs = g.fs; r0 = -1; r1 = -1;
        for (int i = 0; i < 600; i++) begin
            step(1, (i % 2) == 0, 1'b0, 3, 2, g);
            if (g.fs && prev_fs == 0) begin
                if (r0 < 0) r0 = i;
                else if (r1 < 0) r1 = i;
            end
            prev_fs = g.fs;
        end
        check_i("B half-rate frame period", r1 - r0, 300);

        // ---- Reset mid-frame, with and without pixEn ----
        step(1, 1'b1, 1'b1, 0, 0, g);
        for (int i = 0; i < 5 * 15 + 7; i++) step(1, 1'b1, 1'b0, 0, 0, g);
        step(1, 1'b1, 1'b1, 0, 0, g);
        step(1, 1'b1, 1'b0, 0, 0, g);
        check_i("B post-reset frameStart", int'(g.fs), 1);
        check_i("B post-reset xPos", $signed(g.x), -2);
        check_i("B post-reset yPos", $signed(g.y), -1);
        for (int i = 0; i < 30; i++) step(1, 1'b1, 1'b0, 1, 1, g);
        step(1, 1'b0, 1'b1, 1, 1, g);
        check_i("B reset w/o pixEn xPos", $signed(g.x), -2);
        check_i("B reset w/o pixEn hSync", int'(g.hs), 1);

        // ---- Random enables, shifts and occasional resets ----
        for (int i = 0; i < 500; i++) begin
            step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), g);
        end

        // ---- Active-low sync, 400-cycle line ----
        step(2, 1'b0, 1'b1, 0, 0, g);
        check_i("C reset hSync", int'(g.hs), 1);
        check_i("C reset vSync", int'(g.vs), 1);
        lo_cnt = 0; first_lo = -1;
        for (int i = 0; i < 401; i++) begin
            step(2, 1'b1, 1'b0, 0, 0, g);
            if (i < 400 && g.hs == 1'b0) begin
                lo_cnt++;
                if (first_lo < 0) first_lo = i;
            end
        end
        check_i("C hSync low count", lo_cnt, 48);
        check_i("C hSync low start", first_lo, 352);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_generator.md
# video_timing_generator

Parametrised raster timing generator driving the video path: free-running column/line counters, programmable porch/sync/active geometry, sync polarity, per-frame display shift and a pixel clock enable. Produces registered sync, blanking, line/frame strobes and signed pixel coordinates consumed by the tile/sprite renderers and the DAC stage. Defaults reproduce the current 310 x 263, 256 x 192 NTSC-style raster.

## Interface
- H_ACTIVE, 256, active pixels per line
- H_BACK, 9, back-porch cycles (line starts here)
- H_FRONT, 22, front-porch cycles
- H_SYNC, 23, hsync cycles (end of line)
- V_ACTIVE, 192, active lines
- V_BACK, 26, back-porch lines
- V_FRONT, 42, front-porch lines
- V_SYNC, 3, vsync lines (end of frame)
- H_SYNC_POL, 1, active level of hSync
- V_SYNC_POL, 1, active level of vSync
- SHIFT_W, 4, width of shift inputs
- POS_W, 10, width of signed xPos/yPos
- clk  in  1  pixel-domain clock
- reset  in  1  synchronous, active-high
- pixEn  in  1  clock enable; counters/outputs advance only when high
- hShift  in  SHIFT_W  unsigned horizontal display offset
- vShift  in  SHIFT_W  unsigned vertical display offset
- hSync  out  1  horizontal sync, level per H_SYNC_POL
- vSync  out  1  vertical sync, level per V_SYNC_POL
- hBlank  out  1  high outside shifted horizontal active window
- vBlank  out  1  high outside shifted vertical active window
- isActive  out  1  !hBlank && !vBlank
- lineStart  out  1  one-enable pulse at column 0
- frameStart  out  1  one-enable pulse at column 0, line 0
- xPos  out  POS_W  signed pixel x
- yPos  out  POS_W  signed pixel y

## Operation
- H_TOTAL = H_BACK+H_ACTIVE+H_FRONT+H_SYNC (default 310); V_TOTAL likewise (default 263). Counter widths = clog2(total).
- column counts 0..H_TOTAL-1, wraps to 0; on wrap line increments, wraps 0 after V_TOTAL-1.
- Shift latch: hShiftL/vShiftL load hShift/vShift on the enabled edge where column = H_TOTAL-1 and line = V_TOTAL-1, and during reset. Changes at other times take effect at next frame only; no mid-frame tearing.
- xPos = column - H_BACK - hShiftL, yPos = line - V_BACK - vShiftL, computed at POS_W signed, zero-extending all operands.
- hBlank = !(0 <= xPos < H_ACTIVE); vBlank = !(0 <= yPos < V_ACTIVE).
- hSync active when column >= H_TOTAL-H_SYNC (default 287..309); vSync active when line >= V_TOTAL-V_SYNC (default 260..262). Sync is not shifted.
- Elaboration checks (fatal): H_FRONT >= 2^SHIFT_W-1, V_FRONT >= 2^SHIFT_W-1 (shifted window never reaches sync); 2^(POS_W-1) > max(H_TOTAL, V_TOTAL); all geometry params >= 1.

## Timing
- All outputs registered; describe the counter state sampled on the same enabled edge: one enabled cycle latency from counters.
- pixEn low: counters, shift latches and all outputs hold (strobes included; downstream qualifies strobes with pixEn).
- Reset (dominates pixEn): counters 0, shift latches load inputs, hSync = !H_SYNC_POL, vSync = !V_SYNC_POL, hBlank = vBlank = 1, isActive = 0, lineStart = frameStart = 0, xPos = -H_BACK, yPos = -V_BACK.
- First enabled edge after reset: outputs show (0,0): frameStart = lineStart = 1.
- Reset mid-line/mid-frame: immediate return to reset state on that edge; no partial-line completion.
- Simultaneous column and line wrap on same edge: line -> 0, column -> 0, shift latch loads.

## Test plan
- Defaults, pixEn = 1, shifts 0, release reset: hSync period 310 cycles, active 23; lineStart every 310; frameStart every 81530 cycles; vSync active 3 lines.
- Count isActive per frame = 49152; first active output at line 26, column 9 with xPos = 0, yPos = 0; last at xPos = 255, yPos = 191.
- hShift = 15, vShift = 7 applied mid-frame: current frame unchanged; next frame first active at column 24, line 33; hSync timing unchanged.
- pixEn = 1 every other cycle: all periods exactly double; outputs stable during disabled cycles.
- H_SYNC_POL = 0, V_SYNC_POL = 0, H_ACTIVE = 320, H_BACK = 16, H_FRONT = 16, H_SYNC = 48: hSync low 48 of 400; reset value of hSync = 1.
- Reset asserted at line 100, column 150 for one cycle: next enabled output shows frameStart = 1, xPos = -9, yPos = -26.
